// File: rtl/set_bit_enumerator.sv
// ---------------------------------------------------------------------------
// set_bit_enumerator
//   Expands a WIDTH-bit word into a stream of the indices of its set bits,
//   one per cycle, lowest index first. An all-zero word produces no beats,
//   only a one-cycle zero_seen_o pulse. Valid/ready on both sides.
//
// Ports
//   clock_i       rising-edge clock
//   reset_n_i     synchronous active-low reset
//   in_valid_i    in_data_i is valid
//   in_ready_o    block can accept a word this cycle
//   in_data_i     word to enumerate
//   out_valid_o   beat outputs are valid
//   out_ready_i   consumer accepts the current beat
//   out_index_o   index of lowest remaining set bit
//   out_last_o    current beat is the final set bit of the word
//   out_count_o   0-based ordinal of current beat within the word
//   zero_seen_o   one-cycle pulse: an all-zero word was accepted
//
// State | meaning
// IDLE  | no word in flight, ready for a new one
// SCAN  | pend_q holds unemitted bits (never zero), one beat offered per cycle
// ---------------------------------------------------------------------------
module set_bit_enumerator #(
   parameter int WIDTH = 32,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clock_i,
   input  logic             reset_n_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [IDX_W-1:0] out_index_o,
   output logic             out_last_o,
   output logic [IDX_W:0]   out_count_o,
   output logic             zero_seen_o
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic [IDX_W:0]   cnt_q, cnt_d;
   logic             zero_q, zero_d;

   logic [WIDTH-1:0] pend_rest;
   logic [IDX_W-1:0] low_idx;
   logic             take;
   logic             accept;

   // pend with its lowest set bit cleared; zero means one bit remains
   assign pend_rest = pend_q & (pend_q - WIDTH'(1));

   always_comb begin
      low_idx = '0;
      for (int i = WIDTH-1; i >= 0; i--) begin
         if (pend_q[i]) low_idx = IDX_W'(i);
      end
   end

   // reset_n gates both handshakes so nothing transfers in a reset cycle
   assign out_valid_o = reset_n_i && (state_q == SCAN);
   assign out_index_o = low_idx;
   assign out_last_o  = (pend_rest == '0);
   assign out_count_o = cnt_q;
   assign zero_seen_o = zero_q;

   assign take   = out_valid_o && out_ready_i;
   // out_ready_i -> in_ready_o is combinational so words chain with no bubble
   assign in_ready_o = reset_n_i && ((state_q == IDLE) || (take && out_last_o));
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      zero_d  = 1'b0;

      if (take) begin
         if (!out_last_o) begin
            pend_d = pend_rest;
            cnt_d  = cnt_q + (IDX_W+1)'(1);
         end else begin
            state_d = IDLE;
            pend_d  = '0;
         end
      end

      if (accept) begin
         if (in_data_i != '0) begin
            state_d = SCAN;
            pend_d  = in_data_i;
            cnt_d   = '0;
         end else begin
            zero_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         pend_q  <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_n_i && state_q == SCAN) begin
         assert (pend_q != '0);
      end
   end

endmodule

// File: tb/tb_set_bit_enumerator.sv
// ---------------------------------------------------------------------------
// tb_set_bit_enumerator
//   Directed scenarios plus a randomized stream checked against a queue of
//   expected beats built directly from each word's set bits.
// ---------------------------------------------------------------------------
module tb_set_bit_enumerator;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_index;
   logic        out_last;
   logic [5:0]  out_count;
   logic        zero_seen;

   int errors = 0;
   int checks = 0;

   set_bit_enumerator #(.WIDTH(32), .IDX_W(5)) dut (
      .clock_i     (clk),
      .reset_n_i   (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_index_o (out_index),
      .out_last_o  (out_last),
      .out_count_o (out_count),
      .zero_seen_o (zero_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic to_sample();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b1;
      to_drive();
      to_drive();
      to_sample();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++;
      if ({out_valid, zero_seen, out_count} !== 8'h00) begin
         errors++; $display("FAIL reset_outs got v=%b z=%b cnt=%0d exp 0/0/0", out_valid, zero_seen, out_count);
      end
      to_drive();
      rst_n = 1'b1; in_valid = 1'b0;
      to_sample();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++; $display("FAIL post_reset got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
      end
      to_drive();
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_data = 32'h1; out_ready = 1'b1;
      to_sample();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL single_accept_rdy got=%b exp=1", in_ready); end
      to_drive();
      in_valid = 1'b0;
      to_sample();
      checks++;
      if ({out_valid, out_index, out_last, out_count} !== {1'b1, 5'd0, 1'b1, 6'd0}) begin
         errors++; $display("FAIL single_beat got v=%b idx=%0d last=%b cnt=%0d exp 1/0/1/0",
                            out_valid, out_index, out_last, out_count);
      end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL single_last_rdy got=%b exp=1", in_ready); end
      to_drive();
      to_sample();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_idle got v=%b exp=0", out_valid); end
      to_drive();
   endtask

   task automatic test_two_bits();
      in_valid = 1'b1; in_data = 32'h8000_0001; out_ready = 1'b1;
      to_drive();
      in_valid = 1'b0;
      to_sample();
      checks++;
      if ({out_valid, out_index, out_last, out_count, in_ready} !== {1'b1, 5'd0, 1'b0, 6'd0, 1'b0}) begin
         errors++; $display("FAIL two_beat0 got v=%b idx=%0d last=%b cnt=%0d rdy=%b exp 1/0/0/0/0",
                            out_valid, out_index, out_last, out_count, in_ready);
      end
      to_drive();
      to_sample();
      checks++;
      if ({out_valid, out_index, out_last, out_count, in_ready} !== {1'b1, 5'd31, 1'b1, 6'd1, 1'b1}) begin
         errors++; $display("FAIL two_beat1 got v=%b idx=%0d last=%b cnt=%0d rdy=%b exp 1/31/1/1/1",
                            out_valid, out_index, out_last, out_count, in_ready);
      end
      to_drive();
      to_sample();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL two_idle got v=%b exp=0", out_valid); end
      to_drive();
   endtask

   task automatic test_all_ones_stall();
      int e = 0;
      int c = 0;
      in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = 1'b1;
      to_drive();
      in_valid = 1'b0;
      while (e < 32 && c < 100) begin
         out_ready = (c % 2 == 0);
         to_sample();
         checks++;
         if ({out_valid, out_index, out_last, out_count} !== {1'b1, 5'(e), (e == 31), 6'(e)}) begin
            errors++; $display("FAIL ones_beat%0d got v=%b idx=%0d last=%b cnt=%0d exp 1/%0d/%0d/%0d",
                               e, out_valid, out_index, out_last, out_count, e, (e == 31), e);
         end
         if (out_ready) e++;
         c++;
         to_drive();
      end
      checks++;
      if (e != 32) begin errors++; $display("FAIL ones_timeout got beats=%0d exp=32", e); end
      out_ready = 1'b1;
      to_sample();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_idle got v=%b exp=0", out_valid); end
      to_drive();
   endtask

   task automatic test_zero_word();
      in_valid = 1'b1; in_data = 32'h0; out_ready = 1'b1;
      to_sample();
      checks++;
      if ({in_ready, zero_seen} !== 2'b10) begin
         errors++; $display("FAIL zero_accept got rdy=%b z=%b exp rdy=1 z=0", in_ready, zero_seen);
      end
      to_drive();
      in_valid = 1'b0;
      to_sample();
      checks++;
      if ({zero_seen, out_valid, in_ready} !== 3'b101) begin
         errors++; $display("FAIL zero_pulse got z=%b v=%b rdy=%b exp 1/0/1", zero_seen, out_valid, in_ready);
      end
      to_drive();
      to_sample();
      checks++;
      if ({zero_seen, out_valid, in_ready} !== 3'b001) begin
         errors++; $display("FAIL zero_after got z=%b v=%b rdy=%b exp 0/0/1", zero_seen, out_valid, in_ready);
      end
      to_drive();
   endtask

   task automatic test_back_to_back();
      in_valid = 1'b1; in_data = 32'h6; out_ready = 1'b1;
      to_drive();
      in_data = 32'h100;
      to_sample();
      checks++;
      if ({out_valid, out_index, out_last, out_count, in_ready} !== {1'b1, 5'd1, 1'b0, 6'd0, 1'b0}) begin
         errors++; $display("FAIL b2b_beat0 got v=%b idx=%0d last=%b cnt=%0d rdy=%b exp 1/1/0/0/0",
                            out_valid, out_index, out_last, out_count, in_ready);
      end
      to_drive();
      to_sample();
      checks++;
      if ({out_valid, out_index, out_last, out_count, in_ready} !== {1'b1, 5'd2, 1'b1, 6'd1, 1'b1}) begin
         errors++; $display("FAIL b2b_beat1 got v=%b idx=%0d last=%b cnt=%0d rdy=%b exp 1/2/1/1/1",
                            out_valid, out_index, out_last, out_count, in_ready);
      end
      to_drive();
      in_valid = 1'b0;
      to_sample();
      checks++;
      if ({out_valid, out_index, out_last, out_count} !== {1'b1, 5'd8, 1'b1, 6'd0}) begin
         errors++; $display("FAIL b2b_beat2 got v=%b idx=%0d last=%b cnt=%0d exp 1/8/1/0",
                            out_valid, out_index, out_last, out_count);
      end
      to_drive();
      to_sample();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got v=%b exp=0", out_valid); end
      to_drive();
   endtask

   task automatic test_reset_mid_stream();
      in_valid = 1'b1; in_data = 32'h0000_F000; out_ready = 1'b1;
      to_drive();
      in_valid = 1'b0;
      to_sample();
      checks++;
      if ({out_valid, out_index} !== {1'b1, 5'd12}) begin
         errors++; $display("FAIL rmid_beat0 got v=%b idx=%0d exp 1/12", out_valid, out_index);
      end
      to_drive();
      to_sample();
      checks++;
      if ({out_valid, out_index} !== {1'b1, 5'd13}) begin
         errors++; $display("FAIL rmid_beat1 got v=%b idx=%0d exp 1/13", out_valid, out_index);
      end
      to_drive();
      rst_n = 1'b0;
      to_sample();
      checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
         errors++; $display("FAIL rmid_in_reset got v=%b rdy=%b exp 0/0", out_valid, in_ready);
      end
      to_drive();
      rst_n = 1'b1;
      in_valid = 1'b1; in_data = 32'h4;
      to_sample();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++; $display("FAIL rmid_after got v=%b rdy=%b exp 0/1", out_valid, in_ready);
      end
      to_drive();
      in_valid = 1'b0;
      to_sample();
      checks++;
      if ({out_valid, out_index, out_last, out_count} !== {1'b1, 5'd2, 1'b1, 6'd0}) begin
         errors++; $display("FAIL rmid_new got v=%b idx=%0d last=%b cnt=%0d exp 1/2/1/0",
                            out_valid, out_index, out_last, out_count);
      end
      to_drive();
      to_sample();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle got v=%b exp=0", out_valid); end
      to_drive();
   endtask

   typedef struct packed {
      logic [4:0] idx;
      logic       last;
      logic [5:0] cnt;
   } beat_t;

   task automatic test_random_stream();
      logic [31:0] words[$];
      beat_t       exp_q[$];
      beat_t       b;
      beat_t       got;
      int          wi = 0;
      int          cyc = 0;
      int          n;
      int          k;
      logic        zero_exp = 1'b0;
      logic        hold = 1'b0;
      logic [31:0] w;

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       w = 32'h0;
            1:       w = 32'h1 << $urandom_range(0, 31);
            2:       w = $urandom;
            default: w = $urandom & $urandom & $urandom;
         endcase
         words.push_back(w);
         n = 0;
         for (int j = 0; j < 32; j++) if (w[j]) n++;
         k = 0;
         for (int j = 0; j < 32; j++) begin
            if (w[j]) begin
               b.idx = 5'(j); b.cnt = 6'(k); b.last = (k == n - 1);
               exp_q.push_back(b);
               k++;
            end
         end
      end

      while ((wi < 40 || exp_q.size() > 0) && cyc < 4000) begin
         if (!hold) in_valid = (wi < 40) && ($urandom_range(0, 3) != 0);
         if (wi < 40) in_data = words[wi];
         out_ready = ($urandom_range(0, 2) != 0);
         to_sample();
         checks++;
         if (zero_seen !== zero_exp) begin
            errors++; $display("FAIL rand_zero_seen cyc=%0d got=%b exp=%b", cyc, zero_seen, zero_exp);
         end
         zero_exp = 1'b0;
         if (out_valid === 1'b1) begin
            checks++;
            got = {out_index, out_last, out_count};
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rand_extra_beat cyc=%0d got idx=%0d exp no beat", cyc, out_index);
            end else if (got !== exp_q[0]) begin
               errors++; $display("FAIL rand_beat cyc=%0d got idx=%0d last=%b cnt=%0d exp idx=%0d last=%b cnt=%0d",
                                  cyc, out_index, out_last, out_count, exp_q[0].idx, exp_q[0].last, exp_q[0].cnt);
            end
            if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         end
         if (in_valid && in_ready === 1'b1) begin
            if (words[wi] == 32'h0) zero_exp = 1'b1;
            wi++;
            hold = 1'b0;
         end else begin
            hold = in_valid;
         end
         cyc++;
         to_drive();
      end
      in_valid = 1'b0;
      to_sample();
      checks++;
      if (zero_seen !== zero_exp) begin
         errors++; $display("FAIL rand_zero_seen_end got=%b exp=%b", zero_seen, zero_exp);
      end
      checks++;
      if (wi != 40 || exp_q.size() != 0) begin
         errors++; $display("FAIL rand_timeout got words=%0d beats_left=%0d exp 40/0", wi, exp_q.size());
      end
      to_drive();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      test_reset();
      test_single();
      test_two_bits();
      test_all_ones_stall();
      test_zero_word();
      test_back_to_back();
      test_reset_mid_stream();
      test_random_stream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
